adsr_sequencer: RTL and testbench



---
 rtl/adsr_pkg.sv | 27 ++
 rtl/adsr_sequencer_if.sv | 34 +++
 rtl/adsr_sequencer_gate_sync.sv | 48 ++++
 rtl/adsr_sequencer.sv | 155 +++++++++++++++
 tb/tb_adsr_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adsr_pkg.sv
// ============================================================================
// Module   : adsr_pkg
// Purpose  : Shared phase codes, level limit and default sync depth for the
//            ADSR envelope controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

  localparam int c_sync_stages_default = 2;

  function automatic int unsigned env_max(input int unsigned env_w);
    return (32'd1 << env_w) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adsr_sequencer_if.sv
// ============================================================================
// Module   : adsr_sequencer_if
// Purpose  : Trigger, tick, parameter and envelope signals between the voice
//            control logic and the ADSR sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adsr_sequencer_if #(
  parameter int ENV_W = 8
);
  logic             tick_adsr;
  logic             trig;
  logic [ENV_W-1:0] attack_rate;
  logic [ENV_W-1:0] decay_rate;
  logic [ENV_W-1:0] sustain_level;
  logic [ENV_W-1:0] release_rate;
  logic [ENV_W-1:0] env;
  logic [2:0]       state;
  logic             active;
  logic             done;

  modport master (
    output tick_adsr, trig, attack_rate, decay_rate, sustain_level, release_rate,
    input  env, state, active, done
  );

  modport slave (
    input  tick_adsr, trig, attack_rate, decay_rate, sustain_level, release_rate,
    output env, state, active, done
  );
endinterface

`default_nettype wire

// File: rtl/adsr_sequencer_gate_sync.sv
// ============================================================================
// Module   : gate_sync
// Purpose  : Synchronizes the raw trigger pin and produces registered
//            rise/fall pulses of the synchronized gate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sync
  import adsr_pkg::*;
#(
  parameter int SYNC_STAGES = c_sync_stages_default
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic gate,
  output logic gate_rise,
  output logic gate_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_gate_d;
  logic                   r_rise;
  logic                   r_fall;

  // Edge pulses are registered, so the FSM sees an edge one clock after gate moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_gate_d <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], trig};
      r_gate_d <= r_sync[SYNC_STAGES-1];
      r_rise   <= r_sync[SYNC_STAGES-1] & ~r_gate_d;
      r_fall   <= ~r_sync[SYNC_STAGES-1] & r_gate_d;
    end
  end

  assign gate      = r_sync[SYNC_STAGES-1];
  assign gate_rise = r_rise;
  assign gate_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/adsr_sequencer.sv
// ============================================================================
// Module   : adsr_sequencer
// Purpose  : ADSR envelope FSM and level datapath; phase parameters are
//            latched at phase entry. Define ADSR_RETRIG_EN to let a gate rise
//            during RELEASE restart ATTACK from the current level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adsr_sequencer
  import adsr_pkg::*;
#(
  parameter int ENV_W       = 8,
  parameter int SYNC_STAGES = c_sync_stages_default
) (
  input  logic            clk,
  input  logic            rst,
  adsr_sequencer_if.slave bus
);

  localparam logic [ENV_W-1:0] c_env_max = ENV_W'(env_max(ENV_W));

  adsr_state_t      r_state, w_state_nxt;
  logic [ENV_W-1:0] r_env, w_env_nxt;
  logic [ENV_W-1:0] r_rate_q, w_rate_nxt;
  logic [ENV_W-1:0] r_sus_q, w_sus_nxt;
  logic             r_done, w_done_nxt;
  logic [ENV_W:0]   w_att_sum;
  logic [ENV_W:0]   w_dec_floor;
  logic             w_gate_unused;
  logic             w_gate_rise;
  logic             w_gate_fall;
  logic             w_retrig;

  // Only the edges drive the FSM; the level itself is not needed here.
  gate_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_gate_sync (
    .clk       (clk),
    .rst       (rst),
    .trig      (bus.trig),
    .gate      (w_gate_unused),
    .gate_rise (w_gate_rise),
    .gate_fall (w_gate_fall)
  );

`ifdef ADSR_RETRIG_EN
  assign w_retrig = w_gate_rise;
`else
  assign w_retrig = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_env    <= '0;
      r_rate_q <= '0;
      r_sus_q  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_env    <= w_env_nxt;
      r_rate_q <= w_rate_nxt;
      r_sus_q  <= w_sus_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    w_rate_nxt  = r_rate_q;
    w_sus_nxt   = r_sus_q;
    w_done_nxt  = 1'b0;
    w_att_sum   = {1'b0, r_env} + {1'b0, r_rate_q};
    w_dec_floor = {1'b0, r_sus_q} + {1'b0, r_rate_q};

    case (r_state)
      ST_IDLE: begin
        w_env_nxt = '0;
        if (w_gate_rise) begin
          w_state_nxt = ST_ATTACK;
          w_rate_nxt  = bus.attack_rate;
        end
      end

      ST_ATTACK: begin
        if (w_gate_fall) begin
          w_state_nxt = ST_RELEASE;
          w_rate_nxt  = bus.release_rate;
        end else if (bus.tick_adsr) begin
          // A zero rate would never reach the top by accumulation, so it jumps.
          if ((r_rate_q == '0) || (w_att_sum >= {1'b0, c_env_max})) begin
            w_env_nxt   = c_env_max;
            w_state_nxt = ST_DECAY;
            w_rate_nxt  = bus.decay_rate;
            w_sus_nxt   = bus.sustain_level;
          end else begin
            w_env_nxt = w_att_sum[ENV_W-1:0];
          end
        end
      end

      ST_DECAY: begin
        if (w_gate_fall) begin
          w_state_nxt = ST_RELEASE;
          w_rate_nxt  = bus.release_rate;
        end else if (bus.tick_adsr) begin
          if ((r_rate_q == '0) || ({1'b0, r_env} <= w_dec_floor)) begin
            w_env_nxt   = r_sus_q;
            w_state_nxt = ST_SUSTAIN;
          end else begin
            w_env_nxt = r_env - r_rate_q;
          end
        end
      end

      ST_SUSTAIN: begin
        w_env_nxt = r_sus_q;
        if (w_gate_fall) begin
          w_state_nxt = ST_RELEASE;
          w_rate_nxt  = bus.release_rate;
        end
      end

      ST_RELEASE: begin
        if (w_retrig) begin
          w_state_nxt = ST_ATTACK;
          w_rate_nxt  = bus.attack_rate;
        end else if (bus.tick_adsr) begin
          if ((r_rate_q == '0) || (r_env <= r_rate_q)) begin
            w_env_nxt   = '0;
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_env_nxt = r_env - r_rate_q;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_env_nxt   = '0;
      end
    endcase
  end

  assign bus.env    = r_env;
  assign bus.state  = r_state;
  assign bus.active = (r_state != ST_IDLE);
  assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_adsr_sequencer.sv
// ============================================================================
// Module   : tb_adsr_sequencer
// Purpose  : Self-checking bench for adsr_sequencer: directed envelope
//            scenarios plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adsr_sequencer;

  localparam int ENV_W   = 8;
  localparam int SYNC    = 2;
  localparam int ENV_MAX = 255;
`ifdef ADSR_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adsr_sequencer_if #(.ENV_W(ENV_W)) bus();

  adsr_sequencer #(
    .ENV_W       (ENV_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;

  // Behavioural model: phase number, level, latched rate/sustain, and the raw
  // trigger history (index 0 = value sampled at the latest edge).
  int m_phase, m_env, m_rate, m_sus;
  bit m_done;
  bit hist [0:SYNC+1];

  task automatic model_step();
    bit rise, fall, tk;
    m_done = 1'b0;
    if (rst) begin
      m_phase = 0; m_env = 0; m_rate = 0; m_sus = 0;
      for (int j = 0; j <= SYNC + 1; j++) hist[j] = 1'b0;
      return;
    end
    rise = hist[SYNC] && !hist[SYNC+1];
    fall = !hist[SYNC] && hist[SYNC+1];
    tk   = bus.tick_adsr;
    if (m_phase == 0) begin
      if (rise) begin m_phase = 1; m_rate = bus.attack_rate; end
    end else if (m_phase <= 3 && fall) begin
      m_phase = 4; m_rate = bus.release_rate;
    end else if (m_phase == 1 && tk) begin
      if (m_rate == 0 || m_env + m_rate >= ENV_MAX) begin
        m_env = ENV_MAX; m_phase = 2; m_rate = bus.decay_rate; m_sus = bus.sustain_level;
      end else m_env = m_env + m_rate;
    end else if (m_phase == 2 && tk) begin
      if (m_rate == 0 || m_env <= m_sus + m_rate) begin m_env = m_sus; m_phase = 3; end
      else m_env = m_env - m_rate;
    end else if (m_phase == 4) begin
      if (RETRIG && rise) begin m_phase = 1; m_rate = bus.attack_rate; end
      else if (tk) begin
        if (m_rate == 0 || m_env <= m_rate) begin m_env = 0; m_phase = 0; m_done = 1'b1; end
        else m_env = m_env - m_rate;
      end
    end
    for (int j = SYNC + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = bus.trig;
  endtask

  task automatic cycle(input bit tk);
    bus.tick_adsr = tk;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // One clock with the regular every-4th-clock tick.
  task automatic run_tick();
    cycle(tick_cnt % 4 == 3);
    tick_cnt++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle(1'b0);
    rst = 1'b0;
    tick_cnt = 0;
  endtask

  task automatic test_reset();
    bus.trig = 1'b0;
    do_reset(3);
    n_tests++; if (bus.env !== 8'd0) begin n_fail++; $display("FAIL reset_env: got %0d expected 0", bus.env); end
    n_tests++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    n_tests++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0b expected 0", bus.active); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
  endtask

  task automatic test_envelope();
    int seen[$];
    int exp_seq[8] = '{64, 128, 192, 255, 223, 191, 159, 128};
    int prev, st_at_max, k, dones, done_env, done_state;
    bit bad;
    bus.attack_rate = 8'd64; bus.decay_rate = 8'd32;
    bus.sustain_level = 8'd128; bus.release_rate = 8'd100;
    bus.trig = 1'b1;
    st_at_max = -1;
    for (int i = 0; i < 200 && bus.state !== 3'd3; i++) begin
      prev = bus.env;
      run_tick();
      if (bus.env != prev) begin
        seen.push_back(int'(bus.env));
        if (bus.env == 8'd255) st_at_max = int'(bus.state);
      end
    end
    bad = (seen.size() != 8);
    for (int i = 0; i < 8 && !bad; i++) if (seen[i] != exp_seq[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL ad_sequence: got %0d level changes ending %0d expected 8 ending 128", seen.size(), bus.env); end
    n_tests++; if (st_at_max != 2) begin n_fail++; $display("FAIL attack_to_decay: got state %0d at 255 expected 2", st_at_max); end
    n_tests++; if (bus.state !== 3'd3 || bus.env !== 8'd128) begin n_fail++; $display("FAIL sustain_entry: got state %0d env %0d expected 3/128", bus.state, bus.env); end

    bus.sustain_level = 8'd10;
    for (int i = 0; i < 20; i++) run_tick();
    n_tests++; if (bus.env !== 8'd128) begin n_fail++; $display("FAIL sustain_hold: got %0d expected 128", bus.env); end

    bus.trig = 1'b0;
    k = 0;
    while (k < 12 && bus.state !== 3'd4) begin run_tick(); k++; end
    n_tests++; if (k - 1 != SYNC + 1) begin n_fail++; $display("FAIL release_latency: got %0d edges expected %0d", k - 1, SYNC + 1); end

    seen.delete(); dones = 0; done_env = -1; done_state = -1;
    for (int i = 0; i < 40; i++) begin
      prev = bus.env;
      run_tick();
      if (bus.env != prev) seen.push_back(int'(bus.env));
      if (bus.done === 1'b1) begin dones++; done_env = int'(bus.env); done_state = int'(bus.state); end
    end
    bad = (seen.size() != 2) || (seen[0] != 28) || (seen[1] != 0);
    n_tests++; if (bad) begin n_fail++; $display("FAIL release_sequence: got %0d changes ending %0d expected 28,0", seen.size(), bus.env); end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL done_count: got %0d expected 1", dones); end
    n_tests++; if (done_env != 0 || done_state != 0) begin n_fail++; $display("FAIL done_coincide: got env %0d state %0d expected 0/0", done_env, done_state); end
  endtask

  task automatic test_fall_on_tick();
    do_reset(2);
    bus.attack_rate = 8'd64; bus.release_rate = 8'd100;
    bus.trig = 1'b1;
    for (int i = 0; i < 10 && bus.state !== 3'd1; i++) cycle(1'b0);
    cycle(1'b1); cycle(1'b0); cycle(1'b1); cycle(1'b0);
    n_tests++; if (bus.env !== 8'd128 || bus.state !== 3'd1) begin n_fail++; $display("FAIL attack_128: got env %0d state %0d expected 128/1", bus.env, bus.state); end
    bus.trig = 1'b0;
    cycle(1'b0); cycle(1'b0); cycle(1'b0); cycle(1'b1);
    n_tests++; if (bus.state !== 3'd4 || bus.env !== 8'd128) begin n_fail++; $display("FAIL fall_on_tick: got state %0d env %0d expected 4/128", bus.state, bus.env); end
    cycle(1'b1);
    n_tests++; if (bus.env !== 8'd28) begin n_fail++; $display("FAIL release_step: got %0d expected 28", bus.env); end
  endtask

  task automatic test_retrig();
    int dones;
    bus.trig = 1'b0;
    do_reset(2);
    bus.attack_rate = 8'd0; bus.decay_rate = 8'd0;
    bus.sustain_level = 8'd160; bus.release_rate = 8'd100;
    bus.trig = 1'b1;
    for (int i = 0; i < 10 && bus.state !== 3'd1; i++) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    n_tests++; if (bus.env !== 8'd160 || bus.state !== 3'd3) begin n_fail++; $display("FAIL zero_rate_sustain: got env %0d state %0d expected 160/3", bus.env, bus.state); end
    bus.trig = 1'b0;
    for (int i = 0; i < 10 && bus.state !== 3'd4; i++) cycle(1'b0);
    cycle(1'b1);
    n_tests++; if (bus.env !== 8'd60 || bus.state !== 3'd4) begin n_fail++; $display("FAIL release_60: got env %0d state %0d expected 60/4", bus.env, bus.state); end
    bus.attack_rate = 8'd64;
    bus.trig = 1'b1;
    dones = 0;
    for (int i = 0; i < SYNC + 2; i++) begin cycle(1'b0); if (bus.done === 1'b1) dones++; end
`ifdef ADSR_RETRIG_EN
    n_tests++; if (bus.state !== 3'd1 || bus.env !== 8'd60) begin n_fail++; $display("FAIL retrig_enter: got state %0d env %0d expected 1/60", bus.state, bus.env); end
    cycle(1'b1); if (bus.done === 1'b1) dones++;
    n_tests++; if (bus.env !== 8'd124 || bus.state !== 3'd1) begin n_fail++; $display("FAIL retrig_step: got env %0d state %0d expected 124/1", bus.env, bus.state); end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL retrig_done: got %0d pulses expected 0", dones); end
`else
    n_tests++; if (bus.state !== 3'd4 || bus.env !== 8'd60) begin n_fail++; $display("FAIL rise_ignored: got state %0d env %0d expected 4/60", bus.state, bus.env); end
    cycle(1'b1);
    n_tests++; if (bus.env !== 8'd0 || bus.state !== 3'd0 || bus.done !== 1'b1) begin n_fail++; $display("FAIL release_finish: got env %0d state %0d done %0b expected 0/0/1", bus.env, bus.state, bus.done); end
`endif
  endtask

  task automatic test_reset_mid_decay();
    bus.trig = 1'b0;
    do_reset(2);
    bus.attack_rate = 8'd0; bus.decay_rate = 8'd1; bus.sustain_level = 8'd0;
    bus.trig = 1'b1;
    for (int i = 0; i < 10 && bus.state !== 3'd1; i++) cycle(1'b0);
    cycle(1'b1); cycle(1'b1); cycle(1'b1);
    n_tests++; if (bus.state !== 3'd2 || bus.env !== 8'd253) begin n_fail++; $display("FAIL mid_decay: got state %0d env %0d expected 2/253", bus.state, bus.env); end
    rst = 1'b1;
    cycle(1'b1);
    n_tests++; if (bus.env !== 8'd0 || bus.state !== 3'd0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_decay: got env %0d state %0d done %0b expected 0/0/0", bus.env, bus.state, bus.done); end
    bus.attack_rate = 8'd0; bus.decay_rate = 8'd0; bus.sustain_level = 8'd77;
    rst = 1'b0;
    for (int i = 0; i < 10 && bus.state !== 3'd1; i++) cycle(1'b0);
    cycle(1'b1);
    n_tests++; if (bus.env !== 8'd255 || bus.state !== 3'd2) begin n_fail++; $display("FAIL zero_attack: got env %0d state %0d expected 255/2", bus.env, bus.state); end
    cycle(1'b1);
    n_tests++; if (bus.env !== 8'd77 || bus.state !== 3'd3) begin n_fail++; $display("FAIL zero_decay: got env %0d state %0d expected 77/3", bus.env, bus.state); end
  endtask

  function automatic logic [7:0] rand_rate();
    if ($urandom_range(0, 5) == 0) return 8'd0;
    return 8'($urandom_range(1, 60));
  endfunction

  task automatic test_random();
    int dwell;
    bus.trig = 1'b0;
    do_reset(2);
    dwell = 0;
    for (int i = 0; i < 5000; i++) begin
      if (dwell == 0) begin
        bus.trig = ~bus.trig;
        dwell = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 150);
      end
      dwell--;
      if ($urandom_range(0, 3) == 0) bus.attack_rate   = rand_rate();
      if ($urandom_range(0, 3) == 0) bus.decay_rate    = rand_rate();
      if ($urandom_range(0, 3) == 0) bus.release_rate  = rand_rate();
      if ($urandom_range(0, 3) == 0) bus.sustain_level = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 999) == 0);
      cycle($urandom_range(0, 3) == 0);
      n_tests++;
      if (bus.env !== 8'(m_env) || bus.state !== 3'(m_phase) || bus.done !== m_done ||
          bus.active !== (m_phase != 0)) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got env %0d state %0d done %0b active %0b expected env %0d state %0d done %0b active %0b",
                 i, bus.env, bus.state, bus.done, bus.active, m_env, m_phase, m_done, (m_phase != 0));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.tick_adsr = 1'b0; bus.trig = 1'b0;
    bus.attack_rate = '0; bus.decay_rate = '0;
    bus.sustain_level = '0; bus.release_rate = '0;
    m_phase = 0; m_env = 0; m_rate = 0; m_sus = 0; m_done = 1'b0;
    for (int j = 0; j <= SYNC + 1; j++) hist[j] = 1'b0;
    test_reset();
    test_envelope();
    test_fall_on_tick();
    test_retrig();
    test_reset_mid_decay();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
